id_stage: RTL

Decode stage of the ZeroCPU five-stage pipeline, directly downstream of the fetch stage. It takes the registered instruction and its PC from the IF/ID boundary and decodes an RV64I integer/load/store subset. It reads operands from an internal 32×64 register file, which is written by the writeback stage, and drives a registered ID/EX bundle to the execute stage. Stall holds the bundle; flush injects a bubble.

---
 rtl/id_stage_pkg.sv | 74 +++++++
 rtl/id_stage_regfile.sv | 43 ++++
 rtl/id_stage.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/id_stage_pkg.sv
// Shared decode constants and types for the ZeroCPU ID stage.
// The optional write-first register-file bypass is selected with ID_WB_BYPASS_EN.
package id_stage_pkg;

    localparam int ADDR_BUS = 64;
    localparam int INST_BUS = 32;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_DW   = 3'b011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    typedef enum logic [1:0] {
        SRC1_RS1  = 2'd0,
        SRC1_ZERO = 2'd1,
        SRC1_PC   = 2'd2
    } src1_sel_e;

    typedef struct packed {
        logic      legal;
        alu_op_e   alu_op;
        src1_sel_e src1_sel;
        logic      src2_imm;
        logic      rd_wen;
        logic      mem_ren;
        logic      mem_wen;
    } dec_ctrl_t;

    // alt selects SUB/SRA over ADD/SRL (funct7 bit 5 / inst[30])
    function automatic alu_op_e f3_to_alu(input logic [2:0] f3, input logic alt);
        alu_op_e op;
        case (f3)
            F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  op = ALU_SLL;
            F3_SLT:  op = ALU_SLT;
            F3_SLTU: op = ALU_SLTU;
            F3_XOR:  op = ALU_XOR;
            F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:   op = ALU_OR;
            F3_AND:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/id_stage_regfile.sv
// 32 x XLEN register file: two combinational reads, one synchronous write, x0 hardwired.
// With ID_WB_BYPASS_EN defined a same-cycle write is forwarded to the read ports.
module id_stage_regfile #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      raddr1_i,
    input  logic [4:0]      raddr2_i,
    output logic [XLEN-1:0] rdata1_o,
    output logic [XLEN-1:0] rdata2_o,
    input  logic            wen_i,
    input  logic [4:0]      waddr_i,
    input  logic [XLEN-1:0] wdata_i
);

    logic [XLEN-1:0] regs_q [32];
    logic            byp1_s;
    logic            byp2_s;

    // Register storage; reset clears every entry, x0 is never written
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wen_i && (waddr_i != 5'd0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

`ifdef ID_WB_BYPASS_EN
    assign byp1_s = wen_i && (raddr1_i == waddr_i);
    assign byp2_s = wen_i && (raddr2_i == waddr_i);
`else
    assign byp1_s = 1'b0;
    assign byp2_s = 1'b0;
`endif

    assign rdata1_o = (raddr1_i == 5'd0) ? '0 : (byp1_s ? wdata_i : regs_q[raddr1_i]);
    assign rdata2_o = (raddr2_i == 5'd0) ? '0 : (byp2_s ? wdata_i : regs_q[raddr2_i]);

endmodule

// File: rtl/id_stage.sv
// ZeroCPU decode stage: RV64I integer/LD/SD decode, register read, registered ID/EX bundle.
// Build option ID_WB_BYPASS_EN enables write-first forwarding in the register file.
module id_stage
    import id_stage_pkg::*;
#(
    parameter int ADDR_W = ADDR_BUS,
    parameter int XLEN   = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [INST_BUS-1:0] instD,
    input  logic [ADDR_W-1:0]   pcD,
    input  logic                validD,
    input  logic                stall,
    input  logic                flush,
    input  logic                wb_wen,
    input  logic [4:0]          wb_waddr,
    input  logic [XLEN-1:0]     wb_wdata,
    output logic                validE,
    output logic [ADDR_W-1:0]   pcE,
    output logic [3:0]          alu_opE,
    output logic [XLEN-1:0]     src1E,
    output logic [XLEN-1:0]     src2E,
    output logic [XLEN-1:0]     rs2_dataE,
    output logic [4:0]          rdE,
    output logic                rd_wenE,
    output logic                mem_renE,
    output logic                mem_wenE,
    output logic                illegalE
);

    logic [6:0]      opcode_s;
    logic [2:0]      funct3_s;
    logic [6:0]      funct7_s;
    logic [XLEN-1:0] imm_i_s, imm_s_s, imm_u_s, shamt_s, imm_s;
    logic [XLEN-1:0] rs1_data_s, rs2_data_s, src1_s;
    dec_ctrl_t       dec_s;

    logic                valid_d, valid_q, illegal_d, illegal_q;
    logic                rd_wen_d, rd_wen_q, mem_ren_d, mem_ren_q, mem_wen_d, mem_wen_q;
    logic [3:0]          alu_op_d, alu_op_q;
    logic [4:0]          rd_d, rd_q;
    logic [ADDR_W-1:0]   pc_d, pc_q;
    logic [XLEN-1:0]     src1_d, src1_q, src2_d, src2_q, rs2_d, rs2_q;

    assign opcode_s = instD[6:0];
    assign funct3_s = instD[14:12];
    assign funct7_s = instD[31:25];
    assign imm_i_s  = {{(XLEN-12){instD[31]}}, instD[31:20]};
    assign imm_s_s  = {{(XLEN-12){instD[31]}}, instD[31:25], instD[11:7]};
    assign imm_u_s  = {{(XLEN-32){instD[31]}}, instD[31:12], 12'h000};
    assign shamt_s  = {{(XLEN-6){1'b0}}, instD[25:20]};

    id_stage_regfile #(.XLEN(XLEN)) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .raddr1_i (instD[19:15]),
        .raddr2_i (instD[24:20]),
        .rdata1_o (rs1_data_s),
        .rdata2_o (rs2_data_s),
        .wen_i    (wb_wen),
        .waddr_i  (wb_waddr),
        .wdata_i  (wb_wdata)
    );

    // Instruction decode: legality, ALU op, operand routing and immediate
    always_comb begin
        dec_s          = '0;
        dec_s.src2_imm = 1'b1;
        imm_s          = imm_i_s;
        case (opcode_s)
            OPC_OP_IMM: begin
                dec_s.alu_op = f3_to_alu(funct3_s, (funct3_s == F3_SR) && instD[30]);
                dec_s.rd_wen = 1'b1;
                if (funct3_s == F3_SLL) begin
                    dec_s.legal = (instD[31:26] == 6'b000000);
                    imm_s       = shamt_s;
                end else if (funct3_s == F3_SR) begin
                    dec_s.legal = (instD[31:26] == 6'b000000) || (instD[31:26] == 6'b010000);
                    imm_s       = shamt_s;
                end else begin
                    dec_s.legal = 1'b1;
                end
            end
            OPC_OP: begin
                dec_s.legal    = (funct7_s == F7_BASE) ||
                                 ((funct7_s == F7_ALT) && ((funct3_s == F3_ADD) || (funct3_s == F3_SR)));
                dec_s.alu_op   = f3_to_alu(funct3_s, funct7_s[5]);
                dec_s.src2_imm = 1'b0;
                dec_s.rd_wen   = 1'b1;
            end
            OPC_LUI: begin
                dec_s.legal    = 1'b1;
                dec_s.src1_sel = SRC1_ZERO;
                dec_s.rd_wen   = 1'b1;
                imm_s          = imm_u_s;
            end
            OPC_AUIPC: begin
                dec_s.legal    = 1'b1;
                dec_s.src1_sel = SRC1_PC;
                dec_s.rd_wen   = 1'b1;
                imm_s          = imm_u_s;
            end
            OPC_LOAD: begin
                dec_s.legal   = (funct3_s == F3_DW);
                dec_s.mem_ren = 1'b1;
                dec_s.rd_wen  = 1'b1;
            end
            OPC_STORE: begin
                dec_s.legal   = (funct3_s == F3_DW);
                dec_s.mem_wen = 1'b1;
                imm_s         = imm_s_s;
            end
            default: begin
                dec_s.legal = 1'b0;
            end
        endcase
    end

    // First operand source select
    always_comb begin
        case (dec_s.src1_sel)
            SRC1_ZERO: src1_s = '0;
            SRC1_PC:   src1_s = XLEN'(pcD);
            default:   src1_s = rs1_data_s;
        endcase
    end

    // Next ID/EX bundle: bubble on flush or empty slot, otherwise the decode
    always_comb begin
        if (flush || !validD) begin
            valid_d   = 1'b0;
            illegal_d = 1'b0;
            rd_wen_d  = 1'b0;
            mem_ren_d = 1'b0;
            mem_wen_d = 1'b0;
            alu_op_d  = 4'd0;
            rd_d      = 5'd0;
            pc_d      = '0;
            src1_d    = '0;
            src2_d    = '0;
            rs2_d     = '0;
        end else begin
            valid_d   = 1'b1;
            illegal_d = !dec_s.legal;
            rd_wen_d  = dec_s.rd_wen && dec_s.legal;
            mem_ren_d = dec_s.mem_ren && dec_s.legal;
            mem_wen_d = dec_s.mem_wen && dec_s.legal;
            alu_op_d  = dec_s.alu_op;
            rd_d      = instD[11:7];
            pc_d      = pcD;
            src1_d    = src1_s;
            src2_d    = dec_s.src2_imm ? imm_s : rs2_data_s;
            rs2_d     = rs2_data_s;
        end
    end

    // ID/EX pipeline register; flush overrides stall so a bubble always lands
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
            rd_wen_q  <= 1'b0;
            mem_ren_q <= 1'b0;
            mem_wen_q <= 1'b0;
            alu_op_q  <= 4'd0;
            rd_q      <= 5'd0;
            pc_q      <= '0;
            src1_q    <= '0;
            src2_q    <= '0;
            rs2_q     <= '0;
        end else if (flush || !stall) begin
            valid_q   <= valid_d;
            illegal_q <= illegal_d;
            rd_wen_q  <= rd_wen_d;
            mem_ren_q <= mem_ren_d;
            mem_wen_q <= mem_wen_d;
            alu_op_q  <= alu_op_d;
            rd_q      <= rd_d;
            pc_q      <= pc_d;
            src1_q    <= src1_d;
            src2_q    <= src2_d;
            rs2_q     <= rs2_d;
        end
    end

    assign validE    = valid_q;
    assign illegalE  = illegal_q;
    assign rd_wenE   = rd_wen_q;
    assign mem_renE  = mem_ren_q;
    assign mem_wenE  = mem_wen_q;
    assign alu_opE   = alu_op_q;
    assign rdE       = rd_q;
    assign pcE       = pc_q;
    assign src1E     = src1_q;
    assign src2E     = src2_q;
    assign rs2_dataE = rs2_q;

endmodule
